// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter unit.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_BR,
    PC_J,
    PC_JR,
    PC_EXC
  } pc_sel_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;
  localparam int unsigned JUMP_FIELD_W = 26;
  localparam int unsigned REGION_W = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; push when full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   top_idx;
  logic [CW-1:0]   cnt_q;

  assign top_idx = ptr_q - PW'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign top     = empty ? '0 : mem_q[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && (!pop || empty)) begin
      mem_q[ptr_q] <= push_data;
      ptr_q        <= ptr_q + PW'(1);
      if (!full) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else if (push && pop) begin
      // Call replacing a return: rewrite the top in place, depth unchanged.
      mem_q[top_idx] <= push_data;
    end else if (pop && !empty) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with prioritised next-PC select, stall, exception redirect,
// EPC capture, misaligned jump-register trap and a return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h8000_0180),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    exc,
  input  logic                    branch_taken,
  input  logic [XLEN-1:0]         signimm,
  input  logic                    jump,
  input  logic [JUMP_FIELD_W-1:0] instr_index,
  input  logic                    jump_reg,
  input  logic [XLEN-1:0]         reg_target,
  input  logic                    link,
  input  logic                    ras_pop,
  output logic [XLEN-1:0]         pc,
  output logic [XLEN-1:0]         pc_plus4,
  output logic [XLEN-1:0]         epc,
  output logic                    addr_err,
  output logic [XLEN-1:0]         ras_top,
  output logic                    ras_empty,
  output logic                    ras_full
);

  // Low bit of the preserved 256 MB region in a J-type target.
  localparam int unsigned SEG_LSB = 32 - REGION_W;

  logic [XLEN-1:0] pc_q, epc_q, next_pc;
  logic            addr_err_q;
  logic            misalign, take_exc, ras_en;
  pc_sel_e         sel;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign misalign = jump_reg && ((reg_target[1:0] & ALIGN_MASK) != 2'b00);
  assign take_exc = exc || misalign;

  always_comb begin
    sel = PC_SEQ;
    if (take_exc)          sel = PC_EXC;
    else if (jump_reg)     sel = PC_JR;
    else if (jump)         sel = PC_J;
    else if (branch_taken) sel = PC_BR;
  end

  always_comb begin
    next_pc = pc_plus4;
    unique case (sel)
      PC_EXC:  next_pc = EXC_VECTOR;
      PC_JR:   next_pc = reg_target;
      PC_J:    next_pc = {pc_plus4[XLEN-1:SEG_LSB], instr_index, 2'b00};
      PC_BR:   next_pc = pc_plus4 + (signimm << 2);
      PC_SEQ:  next_pc = pc_plus4;
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      // Exceptions are not held off by a stall.
      if (take_exc || !stall) begin
        pc_q <= next_pc;
      end
      if (exc) begin
        epc_q <= pc_q;
      end else if (misalign) begin
        epc_q <= reg_target;
      end
      addr_err_q <= misalign;
    end
  end

  assign ras_en = !stall && !take_exc;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (link && ras_en),
    .pop       (ras_pop && ras_en),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer; expected PC / RAS-top values are queued
// when stimulus is driven and popped after the clock edge.
module tb_pc_sequencer;

  localparam logic [31:0] EXC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, exc = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic        jump_reg = 1'b0, link = 1'b0, ras_pop = 1'b0;
  logic [31:0] signimm = '0, reg_target = '0;
  logic [25:0] instr_index = '0;
  logic [31:0] pc, pc_plus4, epc, ras_top;
  logic        addr_err, ras_empty, ras_full;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .exc          (exc),
    .branch_taken (branch_taken),
    .signimm      (signimm),
    .jump         (jump),
    .instr_index  (instr_index),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .link         (link),
    .ras_pop      (ras_pop),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .epc          (epc),
    .addr_err     (addr_err),
    .ras_top      (ras_top),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    stall = 0; exc = 0; branch_taken = 0; jump = 0; jump_reg = 0;
    link = 0; ras_pop = 0; signimm = '0; reg_target = '0; instr_index = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_next(string n, logic [31:0] v);
    exp_q.push_back(v);
    name_q.push_back(n);
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask

  task automatic goto(logic [31:0] addr);
    jump_reg = 1; reg_target = addr;
    step();
    jump_reg = 0; reg_target = '0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    string n;
    clear_inputs();
    rst_n = 0;
    #3;
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", pc); end
    tests++; if (epc !== 32'h0) begin fails++; $display("FAIL reset_epc: got %h want 0", epc); end
    tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL reset_addr_err: got %b", addr_err); end
    tests++;
    if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_top !== 32'h0) begin
      fails++;
      $display("FAIL reset_ras: empty=%b full=%b top=%h want 1 0 0", ras_empty, ras_full, ras_top);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 1; i <= 3; i++) begin
      expect_next($sformatf("seq_%0d", i), 32'(i * 4));
      step();
      e = exp_q.pop_front(); n = name_q.pop_front();
      tests++; if (pc !== e) begin fails++; $display("FAIL %s: pc=%h want %h", n, pc, e); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] e;
    string n;
    logic [31:0] offs [2];
    logic [31:0] tgts [2];
    offs[0] = 32'hFFFF_FFFE; tgts[0] = 32'h0000_00FC;
    offs[1] = 32'h0000_0003; tgts[1] = 32'h0000_0110;
    for (int i = 0; i < 2; i++) begin
      goto(32'h100);
      tests++; if (pc_plus4 !== 32'h104) begin fails++; $display("FAIL pc_plus4: got %h want 104", pc_plus4); end
      branch_taken = 1; signimm = offs[i];
      expect_next($sformatf("branch_%0d", i), tgts[i]);
      step();
      clear_inputs();
      e = exp_q.pop_front(); n = name_q.pop_front();
      tests++; if (pc !== e) begin fails++; $display("FAIL %s: pc=%h want %h", n, pc, e); end
    end
  endtask

  task automatic test_jump();
    logic [31:0] e;
    string n;
    for (int s = 0; s < 2; s++) begin
      goto(32'h1000_0040);
      jump = 1; instr_index = 26'h000_0123; stall = (s == 1);
      expect_next(s == 1 ? "jump_stalled" : "jump", s == 1 ? 32'h1000_0040 : 32'h1000_048C);
      step();
      clear_inputs();
      e = exp_q.pop_front(); n = name_q.pop_front();
      tests++; if (pc !== e) begin fails++; $display("FAIL %s: pc=%h want %h", n, pc, e); end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] e;
    string n;
    goto(32'h300);
    jump_reg = 1; reg_target = 32'h0000_0402;
    expect_next("misalign_jr", EXC);
    step();
    clear_inputs();
    e = exp_q.pop_front(); n = name_q.pop_front();
    tests++; if (pc !== e) begin fails++; $display("FAIL %s: pc=%h want %h", n, pc, e); end
    tests++; if (epc !== 32'h402) begin fails++; $display("FAIL misalign_epc: got %h want 402", epc); end
    tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL misalign_err: got %b want 1", addr_err); end
    expect_next("after_trap", EXC + 32'h4);
    step();
    e = exp_q.pop_front(); n = name_q.pop_front();
    tests++; if (pc !== e) begin fails++; $display("FAIL %s: pc=%h want %h", n, pc, e); end
    tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL err_pulse_end: got %b want 0", addr_err); end
    tests++; if (epc !== 32'h402) begin fails++; $display("FAIL epc_hold: got %h want 402", epc); end
    goto(32'h200);
    exc = 1; stall = 1; jump_reg = 1; reg_target = 32'h0000_0402;
    expect_next("exc_over_stall", EXC);
    step();
    clear_inputs();
    e = exp_q.pop_front(); n = name_q.pop_front();
    tests++; if (pc !== e) begin fails++; $display("FAIL %s: pc=%h want %h", n, pc, e); end
    tests++; if (epc !== 32'h200) begin fails++; $display("FAIL exc_wins_epc: got %h want 200", epc); end
    tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL exc_wins_err: got %b want 1", addr_err); end
  endtask

  task automatic test_ras_fill();
    logic [31:0] e;
    string n;
    logic [31:0] pops [5];
    pops[0] = 32'h10; pops[1] = 32'hC; pops[2] = 32'h8; pops[3] = 32'h0; pops[4] = 32'h0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      link = 1;
      expect_next($sformatf("push_%0d", i), 32'((i + 1) * 4));
      step();
      e = exp_q.pop_front(); n = name_q.pop_front();
      tests++; if (ras_top !== e) begin fails++; $display("FAIL %s: ras_top=%h want %h", n, ras_top, e); end
    end
    link = 0;
    tests++; if (ras_full !== 1'b1) begin fails++; $display("FAIL ras_full: got %b want 1", ras_full); end
    for (int i = 0; i < 5; i++) begin
      ras_pop = 1;
      expect_next($sformatf("pop_%0d", i), pops[i]);
      step();
      e = exp_q.pop_front(); n = name_q.pop_front();
      tests++; if (ras_top !== e) begin fails++; $display("FAIL %s: ras_top=%h want %h", n, ras_top, e); end
      if (i >= 3) begin
        tests++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
          fails++;
          $display("FAIL pop_empty_%0d: empty=%b full=%b want 1 0", i, ras_empty, ras_full);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    string n;
    apply_reset();
    link = 1;
    step();
    step();
    link = 0;
    goto(32'h20);
    tests++; if (ras_top !== 32'h8) begin fails++; $display("FAIL setup_top: got %h want 8", ras_top); end
    link = 1; ras_pop = 1;
    expect_next("push_pop_top", 32'h24);
    step();
    e = exp_q.pop_front(); n = name_q.pop_front();
    tests++; if (ras_top !== e) begin fails++; $display("FAIL %s: ras_top=%h want %h", n, ras_top, e); end
    link = 0;
    expect_next("pop_below", 32'h4);
    step();
    e = exp_q.pop_front(); n = name_q.pop_front();
    tests++; if (ras_top !== e) begin fails++; $display("FAIL %s: ras_top=%h want %h", n, ras_top, e); end
    step();
    tests++; if (ras_empty !== 1'b1) begin fails++; $display("FAIL drained: empty=%b want 1", ras_empty); end
    // pc is now 0x2C; push+pop on an empty stack behaves as a push of 0x30.
    link = 1;
    expect_next("empty_push_pop", 32'h30);
    step();
    e = exp_q.pop_front(); n = name_q.pop_front();
    tests++; if (ras_top !== e || ras_empty !== 1'b0) begin
      fails++; $display("FAIL %s: ras_top=%h empty=%b want %h 0", n, ras_top, ras_empty, e);
    end
    ras_pop = 0;
    rst_n = 0;
    #1;
    tests++;
    if (pc !== 32'h0 || ras_empty !== 1'b1 || ras_top !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset: pc=%h empty=%b top=%h want 0 1 0", pc, ras_empty, ras_top);
    end
    #1;
    rst_n = 1;
    clear_inputs();
  endtask

  task automatic test_ras_gating();
    apply_reset();
    stall = 1; link = 1;
    step();
    tests++;
    if (pc !== 32'h0 || ras_empty !== 1'b1) begin
      fails++; $display("FAIL stall_gate: pc=%h empty=%b want 0 1", pc, ras_empty);
    end
    stall = 0; exc = 1;
    step();
    clear_inputs();
    tests++;
    if (pc !== EXC || ras_empty !== 1'b1 || epc !== 32'h0) begin
      fails++;
      $display("FAIL exc_gate: pc=%h empty=%b epc=%h want %h 1 0", pc, ras_empty, epc, EXC);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_misalign();
    test_ras_fill();
    test_back_to_back();
    test_ras_gating();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
